// File: rtl/keycode_history_display.sv
// keycode_history_display: DEPTH-entry keycode history with debounced scroll/clear buttons and a 7-seg readout.
// Define KEYHIST_REPEAT_EN to push a repeated keycode (separated by a release) instead of suppressing it.

module khd_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset_N,
  input  logic btn_n,
  output logic evt
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic          acc;
  logic [DW-1:0] cnt;

  // Released (1) is the reset level everywhere, so reset release never fires an event.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      sync <= 2'b11;
      acc  <= 1'b1;
      cnt  <= '0;
      evt  <= 1'b0;
    end else begin
      sync <= {sync[0], btn_n};
      evt  <= 1'b0;
      if (sync[1] == acc) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        acc <= sync[1];
        cnt <= '0;
        evt <= ~sync[1];
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end
endmodule

module khd_seg7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module keycode_history_display #(
  parameter int KEY_W           = 8,
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                         Clk,
  input  logic                         Reset_N,
  input  logic [KEY_W-1:0]             keycode,
  input  logic                         scroll_n,
  input  logic                         clear_n,
  output logic [7*(KEY_W/4)-1:0]       hex,
  output logic                         new_key,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH)-1:0]     sel
);
  localparam int NUM_DIGITS = KEY_W / 4;
  localparam int CW         = $clog2(DEPTH + 1);
  localparam int SW         = $clog2(DEPTH);

  logic [DEPTH-1:0][KEY_W-1:0]    hist;
  logic [KEY_W-1:0]               prev;
  logic [1:0]                     btn_n, btn_evt;
  logic                           scr_evt, clr_evt, press;
  logic [KEY_W-1:0]               shown;
  logic [NUM_DIGITS-1:0][6:0]     seg;
  logic [CW-1:0]                  sel_w;

  assign btn_n   = {clear_n, scroll_n};
  assign scr_evt = btn_evt[0];
  assign clr_evt = btn_evt[1];
  assign sel_w   = CW'(sel);

  for (genvar b = 0; b < 2; b++) begin : g_btn
    khd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .Clk(Clk), .Reset_N(Reset_N), .btn_n(btn_n[b]), .evt(btn_evt[b])
    );
  end

  always_comb begin
    press = (keycode != '0) && (keycode != prev);
`ifndef KEYHIST_REPEAT_EN
    // Same key as the newest entry is treated as a repeat, not a new press.
    if (count != '0 && keycode == hist[0]) press = 1'b0;
`endif
  end

  assign shown = hist[sel];
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    khd_seg7 u_seg (.nib(shown[4*d +: 4]), .seg(seg[d]));
  end

  // Priority: clear beats press beats scroll.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      hist    <= '0;
      prev    <= '0;
      count   <= '0;
      sel     <= '0;
      new_key <= 1'b0;
      hex     <= '1;
    end else begin
      prev    <= keycode;
      new_key <= 1'b0;
      if (clr_evt) begin
        hist  <= '0;
        count <= '0;
        sel   <= '0;
      end else if (press) begin
        hist    <= {hist[DEPTH-2:0], keycode};
        count   <= (count == CW'(DEPTH)) ? count : count + CW'(1);
        sel     <= '0;
        new_key <= 1'b1;
      end else if (scr_evt && count != '0) begin
        sel <= (sel_w == count - CW'(1)) ? '0 : sel + SW'(1);
      end
      hex <= (count == '0) ? '1 : seg;
    end
  end
endmodule
